channel_xbar_arbiter: RTL

//  S-source x D-destination channel crossbar: one round-robin arbiter per destination, so up to min(S,D) transfers per cycle.

---
 rtl/channel_xbar_pkg.sv | 35 +++
 rtl/channel_rr_arb.sv | 86 ++++++++
 rtl/channel_xbar_checker.sv | 18 +
 rtl/channel_xbar_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/channel_xbar_pkg.sv
// Shared types and the round-robin search helper for the channel crossbar.
package channel_xbar_pkg;

    localparam int MAX_S   = 64;
    localparam int MAX_LOG = 6;

    typedef struct packed {
        logic               hit;
        logic [MAX_LOG-1:0] idx;
    } rr_pick_t;

    // First set request at or after ptr, wrapping within the n live sources.
    function automatic rr_pick_t rr_pick(input logic [MAX_S-1:0] req, input int n, input int ptr);
        rr_pick_t r;
        int       cand;
        r.hit = 1'b0;
        r.idx = '0;
        for (int k = 0; k < MAX_S; k++) begin
            cand = ptr + k;
            if (cand >= n) begin
                cand = cand - n;
            end else begin
                cand = cand;
            end
            if ((k < n) && !r.hit && req[cand[MAX_LOG-1:0]]) begin
                r.hit = 1'b1;
                r.idx = cand[MAX_LOG-1:0];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/channel_rr_arb.sv
// Per-destination round-robin arbiter with packet lock; the pointer only
// advances on a last-beat accept so fairness is per packet.
module channel_rr_arb
    import channel_xbar_pkg::*;
#(
    parameter int S     = 2,
    parameter int LOG_S = (S > 1) ? $clog2(S) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [S-1:0]     req_i,
    input  logic [S-1:0]     last_i,
    input  logic             free_i,
    output logic [S-1:0]     grant_o,
    output logic [LOG_S-1:0] grant_idx_o
);

    logic [LOG_S-1:0] ptr_q, ptr_d;
    logic             lock_q, lock_d;
    logic [LOG_S-1:0] lock_src_q, lock_src_d;

    logic [MAX_S-1:0] req_ext_s;
    rr_pick_t         pick_s;
    logic [S-1:0]     grant_s;
    logic [LOG_S-1:0] grant_idx_s;
    logic             accept_s;
    logic             last_s;

    // Grant selection: locked owner only, otherwise round-robin search.
    always_comb begin
        req_ext_s          = '0;
        req_ext_s[S-1:0]   = req_i;
        pick_s             = rr_pick(req_ext_s, S, int'(ptr_q));
        grant_s            = '0;
        grant_idx_s        = '0;
        for (int s = 0; s < S; s++) begin
            if (lock_q) begin
                grant_s[s] = req_i[s] && (lock_src_q == LOG_S'(s));
            end else begin
                grant_s[s] = pick_s.hit && (int'(pick_s.idx) == s);
            end
            if (grant_s[s]) begin
                grant_idx_s = LOG_S'(s);
            end else begin
                grant_idx_s = grant_idx_s;
            end
        end
        accept_s = (|grant_s) && free_i;
        last_s   = |(grant_s & last_i);
    end

    // Lock and pointer update on accepted beats.
    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        if (accept_s) begin
            if (last_s) begin
                lock_d = 1'b0;
                ptr_d  = (int'(grant_idx_s) == S - 1) ? '0 : grant_idx_s + LOG_S'(1);
            end else begin
                lock_d     = 1'b1;
                lock_src_d = grant_idx_s;
            end
        end else begin
            lock_d = lock_q;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_src_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
        end
    end

    assign grant_o     = grant_s;
    assign grant_idx_o = grant_idx_s;

endmodule

// File: rtl/channel_xbar_checker.sv
// Flags a valid source addressing a destination that does not exist.
module channel_xbar_checker #(
    parameter int S     = 2,
    parameter int D     = 2,
    parameter int LOG_D = (D > 1) ? $clog2(D) : 1
) (
    input logic                      clk,
    input logic                      rst,
    input logic [S-1:0]              vld_i,
    input logic [S-1:0][LOG_D-1:0]   tgt_i
);

    for (genvar s = 0; s < S; s++) begin : g_tgt
        a_tgt_range: assert property (@(posedge clk) disable iff (rst)
            vld_i[s] |-> (int'(tgt_i[s]) < D));
    end

endmodule

// File: rtl/channel_xbar_arbiter.sv
// S x D channel crossbar with per-destination round-robin, burst lock and
// registered output slots. CHANNEL_XBAR_PERF_EN adds per-destination beat counters.
module channel_xbar_arbiter
    import channel_xbar_pkg::*;
#(
    parameter int S     = 2,
    parameter int D     = 2,
    parameter int WIDTH = 64,
    parameter int LOG_S = (S > 1) ? $clog2(S) : 1,
    parameter int LOG_D = (D > 1) ? $clog2(D) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [S-1:0]                srcVld_i,
    input  logic [S-1:0][LOG_D-1:0]     srcTarget_i,
    input  logic [S-1:0]                srcLast_i,
    input  logic [S-1:0][WIDTH-1:0]     srcDat_i,
    output logic [S-1:0]                srcRdy_o,
    output logic [D-1:0]                dstVld_o,
    output logic [D-1:0]                dstLast_o,
    output logic [D-1:0][LOG_S-1:0]     dstSrc_o,
    output logic [D-1:0][WIDTH-1:0]     dstDat_o,
    input  logic [D-1:0]                dstRdy_i
`ifdef CHANNEL_XBAR_PERF_EN
    ,
    output logic [D-1:0][31:0]          grantCnt_o
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic             last;
        logic [LOG_S-1:0] src;
    } xbar_beat_t;

    logic [D-1:0][S-1:0]     req_s;
    logic [D-1:0][S-1:0]     grant_s;
    logic [D-1:0][LOG_S-1:0] gidx_s;
    logic [D-1:0]            free_s;
    logic [D-1:0]            acc_s;
    logic [S-1:0]            rdy_s;
    xbar_beat_t [D-1:0]      beat_s;

    logic [D-1:0]            vld_q, vld_d;
    xbar_beat_t [D-1:0]      beat_q, beat_d;

    // Request matrix and slot availability; a draining slot can refill at once.
    always_comb begin
        for (int d = 0; d < D; d++) begin
            free_s[d] = !vld_q[d] || dstRdy_i[d];
            for (int s = 0; s < S; s++) begin
                req_s[d][s] = srcVld_i[s] && (srcTarget_i[s] == LOG_D'(d));
            end
        end
    end

    for (genvar d = 0; d < D; d++) begin : g_arb
        channel_rr_arb #(
            .S     (S),
            .LOG_S (LOG_S)
        ) u_arb (
            .clk         (clk),
            .rst         (rst),
            .req_i       (req_s[d]),
            .last_i      (srcLast_i),
            .free_i      (free_s[d]),
            .grant_o     (grant_s[d]),
            .grant_idx_o (gidx_s[d])
        );
    end

    // Source ready: each source requests one destination, so OR across d.
    always_comb begin
        rdy_s = '0;
        for (int s = 0; s < S; s++) begin
            for (int d = 0; d < D; d++) begin
                rdy_s[s] = rdy_s[s] | (grant_s[d][s] & free_s[d]);
            end
        end
        if (rst) begin
            srcRdy_o = '0;
        end else begin
            srcRdy_o = rdy_s;
        end
    end

    // Output slot next state: load on accept, clear on drain, else hold.
    always_comb begin
        vld_d  = vld_q;
        beat_d = beat_q;
        for (int d = 0; d < D; d++) begin
            acc_s[d]       = (|grant_s[d]) && free_s[d];
            beat_s[d].dat  = '0;
            beat_s[d].last = 1'b0;
            beat_s[d].src  = gidx_s[d];
            for (int s = 0; s < S; s++) begin
                beat_s[d].dat  = beat_s[d].dat | ({WIDTH{grant_s[d][s]}} & srcDat_i[s]);
                beat_s[d].last = beat_s[d].last | (grant_s[d][s] & srcLast_i[s]);
            end
            if (acc_s[d]) begin
                vld_d[d]  = 1'b1;
                beat_d[d] = beat_s[d];
            end else if (dstRdy_i[d]) begin
                vld_d[d]  = 1'b0;
            end else begin
                vld_d[d]  = vld_q[d];
            end
        end
    end

    // Output slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            beat_q <= '0;
        end else begin
            vld_q  <= vld_d;
            beat_q <= beat_d;
        end
    end

    always_comb begin
        for (int d = 0; d < D; d++) begin
            dstVld_o[d]  = vld_q[d];
            dstLast_o[d] = beat_q[d].last;
            dstSrc_o[d]  = beat_q[d].src;
            dstDat_o[d]  = beat_q[d].dat;
        end
    end

`ifdef CHANNEL_XBAR_PERF_EN
    logic [D-1:0][31:0] cnt_q, cnt_d;

    // Accepted-beat counters, free-running with wrap.
    always_comb begin
        for (int d = 0; d < D; d++) begin
            cnt_d[d] = cnt_q[d] + {31'd0, acc_s[d]};
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grantCnt_o = cnt_q;
`endif

    channel_xbar_checker #(
        .S     (S),
        .D     (D),
        .LOG_D (LOG_D)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .vld_i (srcVld_i),
        .tgt_i (srcTarget_i)
    );

endmodule
